// File: rtl/gfx256_pixel_unpack.sv
// Streaming unpacker: one 256-bit memory word -> up to 32 right-justified 8/16/24/32-bit pixels.
// Optional GFX256_UNPACK_SKID_EN adds a second word register for back-to-back words with no bubble.
module gfx256_pixel_unpack (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   color_depth_i,
  input  logic         word_valid_i,
  output logic         word_ready_o,
  input  logic [255:0] word_i,
  input  logic [7:0]   start_mb_i,
  input  logic [5:0]   count_i,
  output logic         pix_valid_o,
  input  logic         pix_ready_i,
  output logic [31:0]  pix_o,
  output logic         pix_last_o,
  output logic         clip_o,
  output logic         busy_o
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state_q, state_d;

  logic [255:0] cur_word_q;
  logic [8:0]   cur_pos_q;
  logic [1:0]   cur_depth_q;
  logic [5:0]   cur_left_q;
  logic         clip_q;

  logic [5:0]   bytes_left, avail, in_n;
  logic         in_clip;
  logic [8:0]   in_pos, bpp;
  logic         accept, pix_hs, fin, load_in, load_buf, ready_raw, buf_busy;
  logic [31:0]  pix_raw, mask;
  logic         unused_lsbs;

  assign unused_lsbs = ^start_mb_i[2:0];

  // Pixels that fit entirely between the start byte and the end of the word.
  always_comb begin
    bytes_left = 6'd32 - {1'b0, start_mb_i[7:3]};
    case (color_depth_i)
      2'd0:    avail = bytes_left;
      2'd1:    avail = bytes_left >> 1;
      2'd2:    avail = bytes_left / 6'd3;
      default: avail = bytes_left >> 2;
    endcase
    in_clip = count_i > avail;
    in_n    = in_clip ? avail : count_i;
  end

  assign in_pos = {1'b0, start_mb_i[7:3], 3'b000};
  assign bpp    = {3'b000, ({1'b0, cur_depth_q} + 3'd1), 3'b000};

  assign accept  = word_valid_i & word_ready_o;
  assign pix_hs  = pix_valid_o & pix_ready_i;
  assign fin     = pix_hs & (cur_left_q == 6'd1);
  assign load_in = accept & (in_n != 6'd0) & ((state_q == IDLE) | fin);

`ifdef GFX256_UNPACK_SKID_EN
  logic         buf_valid_q;
  logic [255:0] buf_word_q;
  logic [8:0]   buf_pos_q;
  logic [1:0]   buf_depth_q;
  logic [5:0]   buf_n_q;
  logic         to_buf;

  // Zero-pixel words are never buffered, so a buffered word always has work.
  assign to_buf    = accept & (in_n != 6'd0) & (state_q == EMIT) & ~fin;
  assign load_buf  = fin & buf_valid_q;
  assign ready_raw = (state_q == IDLE) | ~buf_valid_q;
  assign buf_busy  = buf_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_pos_q   <= '0;
      buf_depth_q <= '0;
      buf_n_q     <= '0;
    end else if (to_buf) begin
      buf_valid_q <= 1'b1;
      buf_word_q  <= word_i;
      buf_pos_q   <= in_pos;
      buf_depth_q <= color_depth_i;
      buf_n_q     <= in_n;
    end else if (load_buf) begin
      buf_valid_q <= 1'b0;
    end
  end
`else
  assign load_buf  = 1'b0;
  assign ready_raw = (state_q == IDLE);
  assign buf_busy  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_in) state_d = EMIT;
      EMIT:    if (fin && !(load_in || load_buf)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_word_q  <= '0;
      cur_pos_q   <= '0;
      cur_depth_q <= '0;
      cur_left_q  <= '0;
      clip_q      <= 1'b0;
    end else begin
      clip_q <= accept & in_clip;
      if (load_in) begin
        cur_word_q  <= word_i;
        cur_pos_q   <= in_pos;
        cur_depth_q <= color_depth_i;
        cur_left_q  <= in_n;
      end else if (load_buf) begin
`ifdef GFX256_UNPACK_SKID_EN
        cur_word_q  <= buf_word_q;
        cur_pos_q   <= buf_pos_q;
        cur_depth_q <= buf_depth_q;
        cur_left_q  <= buf_n_q;
`endif
      end else if (pix_hs) begin
        cur_pos_q  <= cur_pos_q + bpp;
        cur_left_q <= cur_left_q - 6'd1;
      end
    end
  end

  always_comb begin
    case (cur_depth_q)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      2'd2:    mask = 32'h00FF_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  assign pix_raw = 32'(cur_word_q >> cur_pos_q);

  // Outputs are forced low while reset is held, not just after the reset edge.
  assign word_ready_o = ~rst_i & ready_raw;
  assign pix_valid_o  = ~rst_i & (state_q == EMIT);
  assign pix_last_o   = pix_valid_o & (cur_left_q == 6'd1);
  assign pix_o        = pix_valid_o ? (pix_raw & mask) : '0;
  assign clip_o       = ~rst_i & clip_q;
  assign busy_o       = ~rst_i & ((state_q == EMIT) | buf_busy);

endmodule

// File: tb/tb_gfx256_pixel_unpack.sv
// Directed self-checking bench for gfx256_pixel_unpack; gap expectation follows GFX256_UNPACK_SKID_EN.
module tb_gfx256_pixel_unpack;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [1:0]   color_depth_i;
  logic         word_valid_i;
  logic         word_ready_o;
  logic [255:0] word_i;
  logic [7:0]   start_mb_i;
  logic [5:0]   count_i;
  logic         pix_valid_o;
  logic         pix_ready_i;
  logic [31:0]  pix_o;
  logic         pix_last_o;
  logic         clip_o;
  logic         busy_o;

  int n_total = 0;
  int n_bad   = 0;

  gfx256_pixel_unpack dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .color_depth_i (color_depth_i),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .word_i        (word_i),
    .start_mb_i    (start_mb_i),
    .count_i       (count_i),
    .pix_valid_o   (pix_valid_o),
    .pix_ready_i   (pix_ready_i),
    .pix_o         (pix_o),
    .pix_last_o    (pix_last_o),
    .clip_o        (clip_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ramp(input logic [7:0] base);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) w[8*i +: 8] = base + 8'(i);
    return w;
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after accept.
  task automatic offer(input logic [255:0] w, input logic [1:0] d, input logic [7:0] s,
                       input logic [5:0] c);
    int t;
    t = 0;
    while (!word_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("offer_ready", 32'(word_ready_o), 1);
    word_i        = w;
    color_depth_i = d;
    start_mb_i    = s;
    count_i       = c;
    word_valid_i  = 1'b1;
    @(negedge clk);
    word_valid_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, got, gaps, exp_gaps;
    logic b_pending;
    logic [7:0] seq [8];

    rst_i = 1'b1; color_depth_i = '0; word_valid_i = 1'b0; word_i = '0;
    start_mb_i = '0; count_i = '0; pix_ready_i = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", 32'(word_ready_o), 0);
    chk("rst_valid", 32'(pix_valid_o), 0);
    chk("rst_last",  32'(pix_last_o), 0);
    chk("rst_clip",  32'(clip_o), 0);
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_pix",   pix_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(word_ready_o), 1);

    // 8bpp, full word
    pix_ready_i = 1'b1;
    offer(ramp(8'h00), 2'd0, 8'h00, 6'd32);
    for (int k = 0; k < 32; k++) begin
      chk("8bpp_valid", 32'(pix_valid_o), 1);
      chk("8bpp_pix",   pix_o, k);
      chk("8bpp_last",  32'(pix_last_o), 32'(k == 31));
      chk("8bpp_clip",  32'(clip_o), 0);
      @(negedge clk);
    end
    chk("8bpp_end_valid", 32'(pix_valid_o), 0);
    chk("8bpp_end_ready", 32'(word_ready_o), 1);

    // 24bpp from byte 1, count 12 clipped to 10
    offer(ramp(8'h00), 2'd2, 8'h08, 6'd12);
    chk("24_clip_pulse", 32'(clip_o), 1);
    for (int k = 0; k < 10; k++) begin
      chk("24_valid", 32'(pix_valid_o), 1);
      chk("24_pix",   pix_o, ((3*k+3) << 16) | ((3*k+2) << 8) | (3*k+1));
      chk("24_last",  32'(pix_last_o), 32'(k == 9));
      if (k == 1) chk("24_clip_once", 32'(clip_o), 0);
      @(negedge clk);
    end
    chk("24_end_valid", 32'(pix_valid_o), 0);

    // 16bpp backpressure
    hs = 0;
    offer(ramp(8'h00), 2'd1, 8'h00, 6'd4);
    for (int c = 0; c < 40 && hs < 4; c++) begin
      chk("bp_valid", 32'(pix_valid_o), 1);
      chk("bp_pix",   pix_o, ((2*hs+1) << 8) | (2*hs));
      chk("bp_last",  32'(pix_last_o), 32'(hs == 3));
      pix_ready_i = ((c % 3) == 0);
      if (pix_ready_i) hs++;
      @(negedge clk);
    end
    pix_ready_i = 1'b1;
    chk("bp_handshakes", hs, 4);
    chk("bp_end_valid", 32'(pix_valid_o), 0);

    // zero count
    offer(ramp(8'h00), 2'd0, 8'h00, 6'd0);
    chk("zc_valid", 32'(pix_valid_o), 0);
    chk("zc_ready", 32'(word_ready_o), 1);
    chk("zc_busy",  32'(busy_o), 0);
    chk("zc_clip",  32'(clip_o), 0);

    // low offset bits ignored: 0x08 and 0x0F both start at byte 1
    for (int v = 0; v < 2; v++) begin
      offer(ramp(8'h00), 2'd0, (v == 0) ? 8'h08 : 8'h0F, 6'd2);
      chk("ofs_pix0",  pix_o, 1);
      chk("ofs_last0", 32'(pix_last_o), 0);
      @(negedge clk);
      chk("ofs_pix1",  pix_o, 2);
      chk("ofs_last1", 32'(pix_last_o), 1);
      @(negedge clk);
      chk("ofs_end", 32'(pix_valid_o), 0);
    end

    // reset after third 32bpp handshake
    offer(ramp(8'h00), 2'd3, 8'h00, 6'd8);
    for (int k = 0; k < 3; k++) begin
      chk("mid_pix", pix_o, ((4*k+3) << 24) | ((4*k+2) << 16) | ((4*k+1) << 8) | (4*k));
      @(negedge clk);
    end
    chk("mid_pix3", pix_o, 32'h0F0E0D0C);
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(pix_valid_o), 0);
    chk("mid_rst_busy",  32'(busy_o), 0);
    chk("mid_rst_last",  32'(pix_last_o), 0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", 32'(word_ready_o), 1);
    chk("mid_rel_valid", 32'(pix_valid_o), 0);
    offer(ramp(8'h40), 2'd3, 8'h00, 6'd2);
    chk("fresh_pix0",  pix_o, 32'h43424140);
    chk("fresh_last0", 32'(pix_last_o), 0);
    @(negedge clk);
    chk("fresh_pix1",  pix_o, 32'h47464544);
    chk("fresh_last1", 32'(pix_last_o), 1);
    @(negedge clk);
    chk("fresh_end", 32'(pix_valid_o), 0);

    // two 4-pixel words back to back
`ifdef GFX256_UNPACK_SKID_EN
    exp_gaps = 0;
`else
    exp_gaps = 1;
`endif
    seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83};
    offer(ramp(8'h00), 2'd0, 8'h00, 6'd4);
    word_i = ramp(8'h80);
    word_valid_i = 1'b1;
    b_pending = 1'b1;
    got = 0;
    gaps = 0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      if (pix_valid_o) begin
        chk("b2b_pix",  pix_o, {24'h0, seq[got]});
        chk("b2b_last", 32'(pix_last_o), 32'((got % 4) == 3));
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      if (b_pending && word_ready_o) b_pending = 1'b0;
      else if (!b_pending) word_valid_i = 1'b0;
      @(negedge clk);
    end
    word_valid_i = 1'b0;
    chk("b2b_count", got, 8);
    chk("b2b_gaps", gaps, exp_gaps);
    chk("b2b_end_valid", 32'(pix_valid_o), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
